// File: rtl/multiplier.sv
`timescale 1ns/1ps
// multiplier: multicycle 32x32->64 MULT/MULTU for the execute stage.
// Radix-2 shift-add on operand magnitudes, one partial product per cycle.
// The sign is applied once at the end. The request is held in `valid`
// until the one-cycle `done` pulse, and the product appears on `c` as {hi, lo}.
module multiplier (
  input  logic        clk,
  input  logic        resetn,
  input  logic        valid,
  input  logic        is_signed,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [63:0] c
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  // Number of shift-add iterations, one per multiplier bit
  localparam logic [5:0] ITERATIONS = 6'd32;

  state_t      state_q, state_d;
  logic [5:0]  count_q, count_d;
  logic [63:0] p_q,     p_d;
  logic [31:0] mcand_q, mcand_d;
  logic        neg_q,   neg_d;
  logic [63:0] c_q,     c_d;
  logic        done_q,  done_d;

  // Operand conditioning and datapath intermediates
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic        neg_in;
  logic [32:0] sum;
  logic [63:0] p_iter;
  logic [63:0] c_final;

  // Operand magnitudes: negate only signed negatives. 0x80000000 maps to
  // itself, which is the right magnitude when read as unsigned.
  always_comb begin
    a_mag  = a;
    b_mag  = b;
    neg_in = 1'b0;
    if (is_signed) begin
      if (a[31]) a_mag = ~a + 32'd1;
      if (b[31]) b_mag = ~b + 32'd1;
      neg_in = a[31] ^ b[31];
    end
  end

  // One shift-add step: add the multiplicand into the high half when the
  // current multiplier bit is set. Then shift the 65-bit {carry, p} right by one.
  always_comb begin
    sum    = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, mcand_q} : 33'd0);
    p_iter = {sum, p_q[31:1]};
  end

  // Sign fix-up of the unsigned magnitude product (64-bit wrap-around)
  always_comb begin
    c_final = neg_q ? (~p_q + 64'd1) : p_q;
  end

  // Next-state logic. Flush overrides everything, including FIN completion.
  // Partial results are simply abandoned because IDLE reloads them.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    p_d     = p_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    c_d     = c_q;
    done_d  = 1'b0;

    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid) begin
            mcand_d = a_mag;
            neg_d   = neg_in;
            p_d     = {32'd0, b_mag};
            count_d = ITERATIONS;
            state_d = ST_BUSY;
          end
        end
        ST_BUSY: begin
          p_d     = p_iter;
          count_d = count_q - 6'd1;
          if (count_q == 6'd1) begin
            state_d = ST_FIN;
          end
        end
        ST_FIN: begin
          c_d     = c_final;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      count_q <= 6'd0;
      p_q     <= 64'd0;
      mcand_q <= 32'd0;
      neg_q   <= 1'b0;
      c_q     <= 64'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign c    = c_q;

endmodule

// File: tb/tb_multiplier.sv
`timescale 1ns/1ps
// tb_multiplier: directed and random multiplies checked against an
// arithmetic reference product, plus latency, flush and reset behaviour.
module tb_multiplier;

  logic        clk;
  logic        resetn;
  logic        valid;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [63:0] c;

  int          total;
  int          passes;
  logic [63:0] last_c;

  multiplier dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .busy      (busy),
    .done      (done),
    .c         (c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the exact mathematical product, taken as a 64-bit pattern
  function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] x, input logic [31:0] y);
    longint sx;
    longint sy;
    logic [63:0] ux;
    logic [63:0] uy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    ux = {32'd0, x};
    uy = {32'd0, y};
    return ux * uy;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Issue one request (called 1 time unit after a rising edge) and track it to done.
  // Operands are scrambled while busy to show that they are latched at the request.
  task automatic run_op(input bit s, input logic [31:0] oa, input logic [31:0] ob,
                        input bit hold, input string tag);
    logic [63:0] exp;
    int lat;
    int bcnt;
    bit seen;
    exp = ref_mul(s, oa, ob);
    is_signed = s;
    a = oa;
    b = ob;
    valid = 1'b1;
    @(posedge clk); #1;                 // E0 sampled the request
    a = $urandom;
    b = $urandom;
    is_signed = 1'($urandom_range(0, 1));
    bcnt = busy ? 1 : 0;
    seen = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        seen = 1'b1;
        lat = k;
        break;
      end
      if (busy) bcnt++;
    end
    check({tag, "/done_seen"}, 64'(seen), 64'd1);
    check({tag, "/latency"}, 64'(lat), 64'd33);
    check({tag, "/busy_cycles"}, 64'(bcnt), 64'd33);
    check({tag, "/busy_in_done"}, 64'(busy), 64'd0);
    check({tag, "/c"}, c, exp);
    $display("op %s signed=%0d a=%h b=%h c=%h exp=%h lat=%0d", tag, s, oa, ob, c, exp, lat);
    last_c = exp;
    if (!hold) begin
      valid = 1'b0;
      @(posedge clk); #1;
      check({tag, "/done_pulse"}, 64'(done), 64'd0);
      check({tag, "/c_held"}, c, exp);
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] corners [4];
    bit saw_done;

    total = 0;
    passes = 0;
    last_c = 64'd0;
    corners[0] = 32'h8000_0000;
    corners[1] = 32'hFFFF_FFFF;
    corners[2] = 32'h0000_0000;
    corners[3] = 32'h7FFF_FFFF;

    resetn = 1'b0;
    valid = 1'b0;
    is_signed = 1'b0;
    a = 32'd0;
    b = 32'd0;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/c", c, 64'd0);
    check("reset/done", 64'(done), 64'd0);
    check("reset/busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // Back-to-back: unsigned max held across done, then 3x4 sampled at E34
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, "umax");
    check("umax/literal", c, 64'hFFFF_FFFE_0000_0001);
    run_op(1'b0, 32'd3, 32'd4, 1'b0, "b2b_3x4");
    check("b2b/literal", c, 64'd12);

    // Signed mixed and corner values
    run_op(1'b1, 32'hFFFF_FFFD, 32'd7, 1'b0, "m3x7");
    check("m3x7/literal", c, 64'hFFFF_FFFF_FFFF_FFEB);
    run_op(1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFF9, 1'b0, "m3xm7");
    check("m3xm7/literal", c, 64'h0000_0000_0000_0015);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, "min_x_min");
    check("min_x_min/literal", c, 64'h4000_0000_0000_0000);
    run_op(1'b1, 32'h8000_0000, 32'd1, 1'b0, "min_x_1");
    check("min_x_1/literal", c, 64'hFFFF_FFFF_8000_0000);
    run_op(1'b0, 32'h8000_0000, 32'd2, 1'b0, "u_min_x_2");
    check("u_min_x_2/literal", c, 64'h0000_0001_0000_0000);
    run_op(1'b1, 32'd0, 32'hFFFF_FFFF, 1'b0, "zero");

    // Flush at cycle 10 of a MULTU 5x6: no done, c keeps prior value
    is_signed = 1'b0;
    a = 32'd5;
    b = 32'd6;
    valid = 1'b1;
    @(posedge clk);                     // E0
    repeat (9) @(posedge clk);          // E1..E9
    #1;
    flush = 1'b1;
    valid = 1'b0;
    @(posedge clk); #1;                 // E10 takes the flush
    flush = 1'b0;
    check("flush/busy", 64'(busy), 64'd0);
    check("flush/done", 64'(done), 64'd0);
    check("flush/c", c, last_c);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("flush/no_done", 64'(saw_done), 64'd0);
    check("flush/c_later", c, last_c);
    $display("flush c=%h prior=%h saw_done=%0d", c, last_c, saw_done);
    run_op(1'b0, 32'd5, 32'd6, 1'b0, "after_flush");
    check("after_flush/literal", c, 64'd30);

    // Asynchronous reset in the middle of BUSY
    is_signed = 1'b1;
    a = 32'd7;
    b = 32'd9;
    valid = 1'b1;
    @(posedge clk);                     // E0
    repeat (15) @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("areset/busy", 64'(busy), 64'd0);
    check("areset/done", 64'(done), 64'd0);
    check("areset/c", c, 64'd0);
    $display("async reset busy=%0d done=%0d c=%h", busy, done, c);
    valid = 1'b0;
    @(posedge clk); #1;
    check("areset/held_busy", 64'(busy), 64'd0);
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd9, 1'b0, "after_reset");

    // Random operands, occasionally drawn from the corner set
    for (int i = 0; i < 16; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : $urandom;
      run_op(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
    valid = 1'b0;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/multiplier.md
# multiplier

Multicycle 32x32→64 integer multiplier for the execute stage. It is the inverse-operation counterpart of the sequential divider and uses the same request/completion style: the stage holds `valid` and stalls until `done`. It implements MULT/MULTU (signed/unsigned) with a radix-2 shift-add datapath, one partial product per cycle, and presents the result as `{hi, lo}` for HI/LO writeback.

## Interface
- No parameters (width fixed at 32-bit operands, 64-bit product).
- `clk` in 1: single clock, all state on rising edge.
- `resetn` in 1: reset, asynchronous, active-low.
- `valid` in 1: operation request; held high by the stage until `done`.
- `is_signed` in 1: 1 = MULT (two's complement), 0 = MULTU; sampled with `valid` in IDLE.
- `a` in 32: multiplicand; sampled in IDLE.
- `b` in 32: multiplier; sampled in IDLE.
- `flush` in 1: synchronous abort from pipeline flush/exception.
- `busy` out 1: high while state ≠ IDLE.
- `done` out 1: registered one-cycle completion pulse.
- `c` out 64: registered product, `c[63:32]` = hi, `c[31:0]` = lo; held until the next completion.

## Operation
- States: IDLE, BUSY, FIN.
- IDLE, `valid`=1 and `flush`=0:
  - Latch `mcand` = |a| (32-bit, unsigned interpretation of magnitude) and `mplier` = |b|.
  - Latch `neg` = `is_signed` & (a[31] ^ b[31]).
  - Clear the 64-bit product register `p`, with `p[31:0]` = `mplier`.
  - Set `count` = 32 and go to BUSY.
- Magnitude: when `is_signed`=1 and the operand bit 31 is set, the magnitude is the 32-bit negation. 0x80000000 yields 0x80000000, which is correct when treated as unsigned. When `is_signed`=0, operands pass through unchanged.
- BUSY, each cycle:
  - `sum[32:0]` = {1'b0, p[63:32]} + (p[0] ? {1'b0, mcand} : 0).
  - `p` ← {sum[32:0], p[31:1]}, a 65-bit right shift keeping the low 64 bits.
  - `count` decrements. When `count` reaches 1 this cycle, go to FIN.
- FIN:
  - `c` ← `neg` ? (~p + 1) : p, computed in 64-bit with wrap-around.
  - `done` ← 1 for exactly one cycle.
  - Go to IDLE.
- `flush`=1 in any state:
  - Next state is IDLE and `done` is 0 next cycle.
  - `c` is unchanged; any partial result is discarded.
  - `flush` takes priority over `valid` and over FIN completion.
- `valid` is ignored outside IDLE. Operand changes during BUSY/FIN have no effect.
- `valid` still high in the cycle after `done` (IDLE) starts a new operation. This is legal and used for back-to-back multiplies.
- Reset (asynchronous, any state): state = IDLE, `count` = 0, `p` = 0, `neg` = 0, `c` = 0, `done` = 0, `busy` = 0. A reset mid-operation produces no `done`.

## Timing
- E0 is the edge that samples `valid` in IDLE; BUSY occupies the cycles after edges E0 through E31.
- Iterations happen at edges E1 through E32; E32 is the transition to FIN.
- E33 registers `c` and `done`. `done` is high between E33 and E34, so latency from request edge to visible result is 33 cycles. The count is fixed and does not depend on the data.
- `busy` is high from after E0 until E33, and low in the `done` cycle.
- The pipeline advances at E34, sampling `done`. The next request may be sampled at E34, giving a throughput of one multiply per 34 cycles.
- `c` changes only at a FIN edge or reset.

## Test plan
- Unsigned max: MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → `done` exactly 33 cycles after the request edge, `c`=0xFFFFFFFE_00000001, `busy` high for 33 cycles.
- Signed mixed: MULT a=0xFFFFFFFD (−3), b=7 → `c`=0xFFFFFFFF_FFFFFFEB. Then a=−3, b=−7 → `c`=0x00000000_00000015.
- Corner values:
  - MULT 0x80000000 × 0x80000000 → 0x40000000_00000000.
  - MULT 0x80000000 × 1 → 0xFFFFFFFF_80000000.
  - MULTU 0x80000000 × 2 → 0x00000001_00000000.
  - MULT 0 × 0xFFFFFFFF → 0, still 33 cycles.
- Flush: start MULTU 5×6 and assert `flush` for one cycle at cycle 10 → no `done`, `c` keeps its prior value, `busy` low next cycle. A subsequent MULTU 5×6 → `c`=30.
- Back-to-back with reset: hold `valid` high across `done` with new operands 3×4 → second `done` at E34+33 with `c`=12. Then pull `resetn` low asynchronously mid-BUSY → `done`=0, `c`=0, `busy`=0 immediately, and a fresh request after release completes correctly.
